// File: rtl/ysyx_23060203_axi_rd_sram.sv
// AXI4 read-only SRAM slave with a side-band preload write port.
// Serves FIXED/INCR/WRAP read bursts of 32-bit beats from a 2^ADDR_W word array
// mapped at byte address BASE. Malformed bursts answer SLVERR on every beat;
// beats whose address falls outside the array answer DECERR on that beat only.
// Optional build macro YSYX_23060203_AXI_RD_SRAM_DELAY_EN inserts LATENCY idle
// cycles (state WAIT) between the AR handshake and the first beat.
// Ports:
//   clock, reset                         clock, synchronous active-high reset
//   arvalid/arready, araddr, arid,
//   arlen, arsize, arburst               AXI4 read-address channel
//   rvalid/rready, rdata, rresp, rid,
//   rlast                                AXI4 read-data channel (registered)
//   wen, waddr, wdata                    preload write port, independent of AXI
module ysyx_23060203_axi_rd_sram #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arid,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic [3:0]        rid,
  output logic              rlast,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned SPAN_SHIFT = ADDR_W + 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] mem [DEPTH];
  logic [31:0] cur_addr;
  logic [7:0]  beat_cnt;   // beats still to load after the current one
  logic [7:0]  len_q;
  logic [3:0]  id_q;
  logic [1:0]  burst_q;
  logic        err_q;      // whole burst answers SLVERR

`ifdef YSYX_23060203_AXI_RD_SRAM_DELAY_EN
  logic [31:0] wait_cnt;
`else
  logic unused_latency;
  assign unused_latency = ^(32'(LATENCY));
`endif

  logic              ar_hs_c;
  logic              wrap_len_ok_c;
  logic              req_err_c;
  logic [31:0]       offset_c;
  logic              in_range_c;
  logic [ADDR_W-1:0] idx_c;
  logic [31:0]       wrap_mask_c;
  logic [31:0]       incr_c;
  logic [31:0]       next_addr_c;
  logic [31:0]       beat_data_c;
  logic [1:0]        beat_resp_c;

  // Request decode: legality of the incoming burst.
  always_comb begin
    ar_hs_c       = arvalid && arready;
    wrap_len_ok_c = (arlen == 8'd1) || (arlen == 8'd3) ||
                    (arlen == 8'd7) || (arlen == 8'd15);
    req_err_c     = (arsize != 3'b010) || (arburst == BURST_RSVD) ||
                    ((arburst == BURST_WRAP) && !wrap_len_ok_c);
  end

  // Beat address decode and next-address generation.
  always_comb begin
    offset_c    = cur_addr - BASE;
    in_range_c  = (offset_c >> SPAN_SHIFT) == 32'd0;
    idx_c       = offset_c[ADDR_W+1:2];
    wrap_mask_c = 32'({len_q, 2'b11});
    incr_c      = cur_addr + 32'd4;
    case (burst_q)
      BURST_FIXED: next_addr_c = cur_addr;
      BURST_WRAP:  next_addr_c = (cur_addr & ~wrap_mask_c) | (incr_c & wrap_mask_c);
      default:     next_addr_c = incr_c;
    endcase
  end

  // Data/status of the beat at cur_addr; burst errors take priority.
  always_comb begin
    beat_data_c = 32'd0;
    beat_resp_c = RESP_OKAY;
    if (err_q) begin
      beat_resp_c = RESP_SLVERR;
    end else if (!in_range_c) begin
      beat_resp_c = RESP_DECERR;
    end else begin
      beat_data_c = mem[idx_c];
    end
  end

  // Preload port, kept out of reset so contents survive it.
  always_ff @(posedge clock) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  // Burst FSM with registered AR/R outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= RESP_OKAY;
      rid      <= 4'd0;
      rdata    <= 32'd0;
      cur_addr <= 32'd0;
      beat_cnt <= 8'd0;
      len_q    <= 8'd0;
      id_q     <= 4'd0;
      burst_q  <= 2'd0;
      err_q    <= 1'b0;
`ifdef YSYX_23060203_AXI_RD_SRAM_DELAY_EN
      wait_cnt <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs_c) begin
            arready  <= 1'b0;
            cur_addr <= araddr;
            beat_cnt <= arlen;
            len_q    <= arlen;
            id_q     <= arid;
            burst_q  <= arburst;
            err_q    <= req_err_c;
`ifdef YSYX_23060203_AXI_RD_SRAM_DELAY_EN
            if (LATENCY == 0) begin
              state <= BURST;
            end else begin
              state    <= WAIT;
              wait_cnt <= 32'(LATENCY - 1);
            end
`else
            state <= BURST;
`endif
          end
        end
        WAIT: begin
`ifdef YSYX_23060203_AXI_RD_SRAM_DELAY_EN
          if (wait_cnt == 32'd0) begin
            state <= BURST;
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
`else
          state <= BURST;
`endif
        end
        BURST: begin
          if (rvalid && rready && rlast) begin
            state   <= IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
          end else if (!rvalid || rready) begin
            // Output slot is free (first beat or just accepted): load next beat.
            rvalid   <= 1'b1;
            rid      <= id_q;
            rdata    <= beat_data_c;
            rresp    <= beat_resp_c;
            rlast    <= (beat_cnt == 8'd0);
            cur_addr <= next_addr_c;
            if (beat_cnt != 8'd0) begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060203_axi_rd_sram.sv
module tb_ysyx_23060203_axi_rd_sram;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned WORDS   = 1 << ADDR_W;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int unsigned LATENCY = 4;
`ifdef YSYX_23060203_AXI_RD_SRAM_DELAY_EN
  localparam int EXP_LAT = LATENCY + 1;
`else
  localparam int EXP_LAT = 1;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              arvalid = 1'b0;
  logic              arready;
  logic [31:0]       araddr = 32'd0;
  logic [3:0]        arid = 4'd0;
  logic [7:0]        arlen = 8'd0;
  logic [2:0]        arsize = 3'd2;
  logic [1:0]        arburst = 2'd1;
  logic              rvalid;
  logic              rready = 1'b0;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic [3:0]        rid;
  logic              rlast;
  logic              wen = 1'b0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [31:0]       wdata = 32'd0;

  logic [31:0] mem_m [WORDS];
  int cmp_cnt = 0;
  int err_cnt = 0;

  ysyx_23060203_axi_rd_sram #(
    .ADDR_W (ADDR_W),
    .BASE   (BASE),
    .LATENCY(LATENCY)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .arvalid(arvalid),
    .arready(arready),
    .araddr (araddr),
    .arid   (arid),
    .arlen  (arlen),
    .arsize (arsize),
    .arburst(arburst),
    .rvalid (rvalid),
    .rready (rready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rid    (rid),
    .rlast  (rlast),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    wen   = 1'b1;
    waddr = ADDR_W'(idx);
    wdata = val;
    step();
    wen = 1'b0;
    mem_m[idx] = val;
  endtask

  // Reference: expected data/resp of beat i, straight from the burst rules.
  function automatic void exp_beat(input logic [31:0] addr, input logic [7:0] len,
                                   input logic [2:0] size, input logic [1:0] burst,
                                   input int i, output logic [31:0] d, output logic [1:0] r);
    logic [31:0] a, bytes, start;
    bit wrap_ok, bad;
    wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
    bad = (size != 3'd2) || (burst == 2'd3) || (burst == 2'd2 && !wrap_ok);
    d = 32'd0;
    r = 2'b00;
    if (bad) begin
      r = 2'b10;
      return;
    end
    if (burst == 2'd0) a = addr;
    else if (burst == 2'd1) a = addr + 32'(4 * i);
    else begin
      bytes = (32'(len) + 32'd1) * 32'd4;
      start = addr - (addr % bytes);
      a = start + ((addr - start) + 32'(4 * i)) % bytes;
    end
    if (a < BASE || a >= BASE + 32'(4 * WORDS)) r = 2'b11;
    else d = mem_m[(a - BASE) / 4];
  endfunction

  // Issue one burst, collect every beat with the chosen rready pattern, check it.
  // rr_mode: 0 always ready, 1 random, 2 repeating 1,0,0,1.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int rr_mode, input string name);
    logic [31:0] ed, sd;
    logic [1:0]  er, sr;
    logic [3:0]  sid;
    logic        sl, el, rr;
    int beat, lat, guard, sidx;
    bit stalled;
    cmp_cnt++;
    if (arready !== 1'b1) begin
      err_cnt++;
      $display("FAIL %s arready_idle: got %b want 1", name, arready);
    end
    araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    cmp_cnt++;
    if (arready !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s arready_after_ar: got %b want 0", name, arready);
    end
    lat = 0;
    while (rvalid !== 1'b1 && lat < 64) begin
      step();
      lat++;
    end
    cmp_cnt++;
    if (lat != EXP_LAT) begin
      err_cnt++;
      $display("FAIL %s first_rvalid_latency: got %0d want %0d", name, lat, EXP_LAT);
      if (lat >= 64) return;
    end
    beat = 0; stalled = 0; guard = 0; sidx = 0;
    sd = '0; sr = '0; sid = '0; sl = 1'b0;
    while (beat <= int'(len) && guard < 4000) begin
      if (rvalid === 1'b1) begin
        cmp_cnt++;
        if (stalled) begin
          if ({rdata, rresp, rid, rlast} !== {sd, sr, sid, sl}) begin
            err_cnt++;
            $display("FAIL %s stall_hold beat%0d: got %h/%b/%h/%b want %h/%b/%h/%b",
                     name, beat, rdata, rresp, rid, rlast, sd, sr, sid, sl);
          end
        end else begin
          exp_beat(addr, len, size, burst, beat, ed, er);
          el = (beat == int'(len));
          if ({rdata, rresp, rid, rlast} !== {ed, er, id, el}) begin
            err_cnt++;
            $display("FAIL %s beat%0d data/resp/id/last: got %h/%b/%h/%b want %h/%b/%h/%b",
                     name, beat, rdata, rresp, rid, rlast, ed, er, id, el);
          end
          sd = rdata; sr = rresp; sid = rid; sl = rlast;
        end
        case (rr_mode)
          0:       rr = 1'b1;
          1:       rr = 1'($urandom_range(0, 1));
          default: rr = (sidx % 4 == 0) || (sidx % 4 == 3);
        endcase
        sidx++;
        rready = rr;
        if (rr) begin
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
        end
      end else begin
        rready = 1'b0;
        if (stalled) begin
          cmp_cnt++;
          err_cnt++;
          $display("FAIL %s rvalid_dropped beat%0d: got 0 want 1", name, beat);
          stalled = 0;
        end
      end
      cmp_cnt++;
      if (arready !== 1'b0) begin
        err_cnt++;
        $display("FAIL %s arready_in_burst: got %b want 0", name, arready);
      end
      step();
      guard++;
    end
    rready = 1'b0;
    if (guard >= 4000) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s burst_timeout: got %0d beats want %0d", name, beat, int'(len) + 1);
    end
    cmp_cnt++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s back_to_idle: got arready=%b rvalid=%b want 1/0", name, arready, rvalid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    cmp_cnt++;
    if ({arready, rvalid, rlast, rresp, rid, rdata} !== {1'b1, 1'b0, 1'b0, 2'b00, 4'd0, 32'd0}) begin
      err_cnt++;
      $display("FAIL reset_state: got arready=%b rvalid=%b rlast=%b rresp=%b rid=%h rdata=%h want 1/0/0/00/0/0",
               arready, rvalid, rlast, rresp, rid, rdata);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_preload();
    for (int i = 0; i < int'(WORDS); i++) preload(i, $urandom);
    preload(0, 32'h11);
    preload(1, 32'h22);
    preload(2, 32'h33);
    preload(3, 32'h44);
  endtask

  task automatic test_wrap_example();
    do_read(32'h8000_0004, 4'h1, 8'd3, 3'd2, 2'b10, 0, "wrap4");
    do_read(32'h8000_0038, 4'h2, 8'd7, 3'd2, 2'b10, 0, "wrap8");
  endtask

  task automatic test_decerr_edge();
    do_read(32'h8000_0FF8, 4'h3, 8'd3, 3'd2, 2'b01, 0, "incr_top_edge");
    do_read(BASE - 32'd8, 4'h4, 8'd3, 3'd2, 2'b01, 0, "incr_bottom_edge");
  endtask

  task automatic test_backpressure();
    do_read(32'h8000_0100, 4'h5, 8'd3, 3'd2, 2'b01, 2, "rready_1001");
    do_read(32'h8000_0200, 4'h6, 8'd5, 3'd2, 2'b00, 1, "fixed_random_rready");
  endtask

  task automatic test_slverr();
    do_read(32'h8000_0010, 4'h7, 8'd2, 3'd2, 2'b10, 0, "wrap_len2");
    do_read(32'h8000_0010, 4'h8, 8'd4, 3'd3, 2'b01, 1, "size8");
    do_read(32'h8000_0010, 4'h9, 8'd1, 3'd2, 2'b11, 0, "burst_rsvd");
  endtask

  task automatic test_reset_mid_burst();
    int g;
    araddr = BASE + 32'h40; arid = 4'h3; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    g = 0;
    while (rvalid !== 1'b1 && g < 64) begin
      step();
      g++;
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    cmp_cnt++;
    if (rvalid !== 1'b1 || rdata !== mem_m[17]) begin
      err_cnt++;
      $display("FAIL mid_reset_second_beat: got rvalid=%b rdata=%h want 1/%h", rvalid, rdata, mem_m[17]);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    cmp_cnt++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || rlast !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset_abandon: got rvalid=%b arready=%b rlast=%b want 0/1/0", rvalid, arready, rlast);
    end
    do_read(BASE + 32'd20, 4'hA, 8'd0, 3'd2, 2'b01, 0, "post_reset_single");
  endtask

  task automatic test_same_cycle_write();
    logic [31:0] old;
    old = mem_m[20];
    araddr = BASE + 32'd80; arid = 4'hC; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    repeat (EXP_LAT - 1) step();
    // This write lands on the same edge that captures the beat.
    wen = 1'b1; waddr = ADDR_W'(20); wdata = ~old;
    step();
    wen = 1'b0;
    mem_m[20] = ~old;
    cmp_cnt++;
    if (rvalid !== 1'b1 || rdata !== old) begin
      err_cnt++;
      $display("FAIL same_cycle_write: got rvalid=%b rdata=%h want 1/%h", rvalid, rdata, old);
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    do_read(BASE + 32'd80, 4'hD, 8'd0, 3'd2, 2'b01, 0, "after_write");
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    logic [1:0]  b;
    for (int n = 0; n < 40; n++) begin
      b = 2'($urandom_range(0, 9) < 1 ? 3 : $urandom_range(0, 2));
      if (b == 2'b10 && $urandom_range(0, 7) != 0) l = 8'((1 << $urandom_range(1, 4)) - 1);
      else l = 8'($urandom_range(0, 15));
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      case ($urandom_range(0, 3))
        0:       a = BASE + 32'(4 * WORDS) - 32'($urandom_range(0, 40));
        1:       a = BASE - 32'($urandom_range(0, 40));
        default: a = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
      endcase
      do_read(a, 4'($urandom), l, s, b, int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_wrap_example();
    test_decerr_edge();
    test_backpressure();
    test_slverr();
    test_reset_mid_burst();
    test_same_cycle_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
